// File: rtl/uart_row_sender.sv
// uart_row_sender: sends a row packet one byte at a time and checks the loader's answer to each byte.
module uart_row_sender #(
   parameter int         BYTE_SIZE_ROW         = 240,
   parameter int         BYTE_SIZE_Y           = 2,
   parameter logic [7:0] END_WORD              = 8'hDD,
   parameter logic [7:0] ANSWER_CODE_TAKE_ROW  = 8'hCC,
   parameter logic [7:0] ANSWER_CODE           = 8'hAA,
   parameter logic [7:0] SUCCESSFULLY_RECEIVED = 8'hFF,
   parameter logic [7:0] NOT_ALL_RECEIVED      = 8'h11,
   parameter int         ANSWER_TIMEOUT        = 500000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] row_y,
   output logic        busy,
   output logic        done,
   output logic [1:0]  status,
   output logic [7:0]  fail_idx,
   output logic [7:0]  err_byte,
   output logic [7:0]  mem_addr,
   input  logic [7:0]  mem_rd_data,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   input  logic [7:0]  rx_data,
   input  logic        rx_done
);
   localparam int CW = $clog2(ANSWER_TIMEOUT);
   localparam logic [7:0] K_PIX = 8'(BYTE_SIZE_Y);
   localparam logic [7:0] K_END = 8'(BYTE_SIZE_Y + BYTE_SIZE_ROW);
   // expiry is decided in the cycle the counter steps onto ANSWER_TIMEOUT-1
   localparam logic [CW-1:0] CNT_LAST = CW'(ANSWER_TIMEOUT - 2);

   typedef enum logic [3:0] {IDLE, FETCH, LOAD, WAIT_TXR, STROBE, WAIT_ANS, CHECK, WAIT_CNT, FINISH} state_t;

   state_t state, state_n;
   logic [15:0] row;
   logic [7:0] k, k_inc, ans, exp_ans;
   logic [CW-1:0] cnt;
   logic expire, next_pix;

   assign k_inc = k + 8'd1;
   assign next_pix = k_inc >= K_PIX && k_inc < K_END;
   assign exp_ans = k < K_PIX ? ANSWER_CODE_TAKE_ROW : ANSWER_CODE;
   assign expire = cnt == CNT_LAST;
   assign busy = state != IDLE && state != FINISH;
   assign done = state == FINISH;
   assign tx_start = state == STROBE;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:     state_n = start ? LOAD : IDLE;
         FETCH:    state_n = LOAD;
         LOAD:     state_n = WAIT_TXR;
         WAIT_TXR: state_n = tx_busy ? WAIT_TXR : STROBE;
         STROBE:   state_n = WAIT_ANS;
         WAIT_ANS: state_n = rx_done ? CHECK : expire ? FINISH : WAIT_ANS;
         CHECK:    state_n = k == K_END ? (ans == NOT_ALL_RECEIVED ? WAIT_CNT : FINISH)
                                        : ans != exp_ans ? FINISH : next_pix ? FETCH : LOAD;
         WAIT_CNT: state_n = rx_done || expire ? FINISH : WAIT_CNT;
         FINISH:   state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row <= '0;
         k <= '0;
         ans <= '0;
         cnt <= '0;
         tx_data <= '0;
         mem_addr <= '0;
         status <= '0;
         fail_idx <= '0;
         err_byte <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               row <= row_y;
               k <= '0;
               status <= '0;
               fail_idx <= '0;
               err_byte <= '0;
            end
            LOAD: tx_data <= k < K_PIX ? (k[0] ? row[15:8] : row[7:0]) : k == K_END ? END_WORD : mem_rd_data;
            STROBE: cnt <= '0;
            WAIT_ANS: begin
               cnt <= cnt + 1'b1;
               if (rx_done) ans <= rx_data;
               else if (expire) begin
                  status <= 2'd3;
                  fail_idx <= k;
               end
            end
            CHECK: begin
               cnt <= '0;
               if (k == K_END ? (ans != SUCCESSFULLY_RECEIVED && ans != NOT_ALL_RECEIVED) : ans != exp_ans) begin
                  status <= 2'd2;
                  fail_idx <= k;
                  err_byte <= ans;
               end else if (k != K_END) begin
                  k <= k_inc;
                  if (next_pix) mem_addr <= k_inc - K_PIX;
               end
            end
            WAIT_CNT: begin
               cnt <= cnt + 1'b1;
               if (rx_done) begin
                  status <= 2'd1;
                  fail_idx <= K_END;
                  err_byte <= rx_data;
               end else if (expire) begin
                  status <= 2'd3;
                  fail_idx <= K_END;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
